// File: rtl/paso8bto32b.sv
// Byte-to-word packer: gathers four consecutive valid bytes into one 32-bit word.
// A gap in valid_in before the fourth byte discards the partial word and pulses err_partial.
module paso8bto32b #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        err_partial
);

    // Handshake: valid_in qualifies data_in on every rising edge. There is no ready
    // signal, so the consumer must take data_out while valid_out is high.
    logic [1:0]  indice;
    logic [7:0]  lane0;
    logic [7:0]  lane1;
    logic [7:0]  lane2;
    logic [31:0] word_next;

    always_comb begin
        word_next = {lane0, lane1, lane2, data_in};
        if (!MSB_FIRST) begin
            word_next = {data_in, lane2, lane1, lane0};
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            indice      <= 2'd0;
            lane0       <= 8'h00;
            lane1       <= 8'h00;
            lane2       <= 8'h00;
            data_out    <= 32'h0;
            valid_out   <= 1'b0;
            err_partial <= 1'b0;
        end else begin
            valid_out   <= 1'b0;
            err_partial <= 1'b0;
            if (valid_in) begin
                case (indice)
                    2'd0: lane0 <= data_in;
                    2'd1: lane1 <= data_in;
                    2'd2: lane2 <= data_in;
                    2'd3: begin
                        data_out  <= word_next;
                        valid_out <= 1'b1;
                    end
                endcase
                // Wraps 3 -> 0 on completion so the next byte starts a fresh word.
                indice <= indice + 2'd1;
            end else if (indice != 2'd0) begin
                indice      <= 2'd0;
                err_partial <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_paso8bto32b.sv
// Self-checking bench for paso8bto32b: both lane orders driven with the same bytes
// and compared against a queue-based reference model.
module tb_paso8bto32b;

    logic        clk_4f;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic [31:0] data_out_m;
    logic        valid_out_m;
    logic        err_partial_m;
    logic [31:0] data_out_l;
    logic        valid_out_l;
    logic        err_partial_l;

    int n_tests;
    int n_fail;

    logic [7:0]  bytes_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] e_data_m;
    logic [31:0] e_data_l;
    logic        e_vo;
    logic        e_err;

    paso8bto32b #(.MSB_FIRST(1'b1)) dut_m (
        .clk_4f      (clk_4f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .data_out    (data_out_m),
        .valid_out   (valid_out_m),
        .err_partial (err_partial_m)
    );

    paso8bto32b #(.MSB_FIRST(1'b0)) dut_l (
        .clk_4f      (clk_4f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .data_out    (data_out_l),
        .valid_out   (valid_out_l),
        .err_partial (err_partial_l)
    );

    // clock / reset
    initial begin
        clk_4f = 1'b0;
        forever #5 clk_4f = ~clk_4f;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: collect valid bytes; four of them make a word.
    task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
        e_vo  = 1'b0;
        e_err = 1'b0;
        if (r) begin
            bytes_q.delete();
            e_data_m = 32'h0;
            e_data_l = 32'h0;
        end else if (v) begin
            bytes_q.push_back(d);
            if (bytes_q.size() == 4) begin
                e_data_m = (32'(bytes_q[0]) << 24) | (32'(bytes_q[1]) << 16) |
                           (32'(bytes_q[2]) << 8)  |  32'(bytes_q[3]);
                e_data_l = (32'(bytes_q[3]) << 24) | (32'(bytes_q[2]) << 16) |
                           (32'(bytes_q[1]) << 8)  |  32'(bytes_q[0]);
                e_vo = 1'b1;
                exp_q.push_back(e_data_m);
                bytes_q.delete();
            end
        end else if (bytes_q.size() != 0) begin
            e_err = 1'b1;
            bytes_q.delete();
        end
    endtask

    // driver: apply inputs, clock once, check all outputs 1 time unit after the edge
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        reset    = r;
        valid_in = v;
        data_in  = d;
        @(posedge clk_4f);
        model_edge(r, v, d);
        #1;
        check_eq("data_out_msb", data_out_m, e_data_m);
        check_eq("data_out_lsb", data_out_l, e_data_l);
        check_eq("valid_out_msb", {31'b0, valid_out_m}, {31'b0, e_vo});
        check_eq("valid_out_lsb", {31'b0, valid_out_l}, {31'b0, e_vo});
        check_eq("err_partial_msb", {31'b0, err_partial_m}, {31'b0, e_err});
        check_eq("err_partial_lsb", {31'b0, err_partial_l}, {31'b0, e_err});
        if (valid_out_m) begin
            if (exp_q.size() > 0) check_eq("word_q", data_out_m, exp_q.pop_front());
            else check_eq("unexpected_word", {31'b0, valid_out_m}, 32'h0);
        end
    endtask

    task automatic send_bytes(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        step(1'b0, 1'b1, b0);
        step(1'b0, 1'b1, b1);
        step(1'b0, 1'b1, b2);
        step(1'b0, 1'b1, b3);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        e_data_m = 32'h0;
        e_data_l = 32'h0;
        e_vo     = 1'b0;
        e_err    = 1'b0;

        // reset held with valid bytes present: nothing captured
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 8'h00);

        // single word
        send_bytes(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        check_eq("deadbeef", data_out_m, 32'hDEADBEEF);
        step(1'b0, 1'b0, 8'h00);
        check_eq("deadbeef_hold", data_out_m, 32'hDEADBEEF);

        // back-to-back words
        send_bytes(8'h01, 8'h02, 8'h03, 8'h04);
        check_eq("b2b_w0", data_out_m, 32'h01020304);
        check_eq("lsb_first", data_out_l, 32'h04030201);
        send_bytes(8'h05, 8'h06, 8'h07, 8'h08);
        check_eq("b2b_w1", data_out_m, 32'h05060708);

        // abort then fresh word
        step(1'b0, 1'b1, 8'hAA);
        step(1'b0, 1'b1, 8'hBB);
        step(1'b0, 1'b0, 8'h00);
        check_eq("abort_err", {31'b0, err_partial_m}, 32'h1);
        send_bytes(8'h11, 8'h22, 8'h33, 8'h44);
        check_eq("after_abort", data_out_m, 32'h11223344);

        // reset mid-word: no error pulse, counting restarts
        step(1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b1, 8'h66);
        step(1'b1, 1'b1, 8'h77);
        send_bytes(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        check_eq("after_reset", data_out_m, 32'hC0C1C2C3);

        // randomized traffic with occasional gaps and resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8),
                 8'($urandom_range(0, 255)));
        end
        step(1'b0, 1'b0, 8'h00);

        check_eq("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
